// File: rtl/ysyx_25070198_mem_arb.sv
// Two-master (IFU/LSU) arbiter for a single memory port, one outstanding transaction, response watchdog.
// Optional build macro MEM_ARB_RR_EN: round-robin on ties instead of fixed LSU priority.
module ysyx_25070198_mem_arb #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ifu_valid,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_ready,
  output logic                ifu_rvalid,
  output logic [DATA_W-1:0]   ifu_rdata,
  output logic                ifu_err,
  input  logic                lsu_valid,
  input  logic                lsu_wen,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_ready,
  output logic                lsu_rvalid,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                lsu_err,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_wen,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_resp_rdata
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e              state_q;
  logic                grant_lsu_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_d;
  logic                req_valid_q;
  logic                wen_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] wmask_q;
  logic                ifu_rvalid_q;
  logic                ifu_err_q;
  logic [DATA_W-1:0]   ifu_rdata_q;
  logic                lsu_rvalid_q;
  logic                lsu_err_q;
  logic [DATA_W-1:0]   lsu_rdata_q;

  logic accept;
  logic pick_lsu;

`ifdef MEM_ARB_RR_EN
  // last_lsu_q = 1 when the previous accept went to the LSU; reset value means "IFU last".
  logic last_lsu_q;

  assign pick_lsu = lsu_valid && (!ifu_valid || !last_lsu_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_lsu_q <= 1'b0;
    end else if (accept) begin
      last_lsu_q <= pick_lsu;
    end
  end
`else
  assign pick_lsu = lsu_valid;
`endif

  // Ready is combinational so the winner sees acceptance in the same IDLE cycle.
  assign accept    = rst && (state_q == IDLE) && (ifu_valid || lsu_valid);
  assign lsu_ready = accept && pick_lsu;
  assign ifu_ready = accept && !pick_lsu;

  assign cnt_d = cnt_q + CNT_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      grant_lsu_q  <= 1'b0;
      cnt_q        <= '0;
      req_valid_q  <= 1'b0;
      wen_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wmask_q      <= '0;
      ifu_rvalid_q <= 1'b0;
      ifu_err_q    <= 1'b0;
      ifu_rdata_q  <= '0;
      lsu_rvalid_q <= 1'b0;
      lsu_err_q    <= 1'b0;
      lsu_rdata_q  <= '0;
    end else begin
      ifu_rvalid_q <= 1'b0;
      ifu_err_q    <= 1'b0;
      lsu_rvalid_q <= 1'b0;
      lsu_err_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            grant_lsu_q <= pick_lsu;
            req_valid_q <= 1'b1;
            state_q     <= REQ;
            if (pick_lsu) begin
              addr_q  <= lsu_addr;
              wen_q   <= lsu_wen;
              wdata_q <= lsu_wdata;
              wmask_q <= lsu_wmask;
            end else begin
              addr_q  <= ifu_addr;
              wen_q   <= 1'b0;
              wdata_q <= '0;
              wmask_q <= '0;
            end
          end
        end
        REQ: begin
          if (mem_req_ready) begin
            req_valid_q <= 1'b0;
            cnt_q       <= '0;
            state_q     <= RESP;
          end
        end
        RESP: begin
          // A response arriving on the timeout cycle still wins over the abort.
          if (mem_resp_valid || (cnt_q == CNT_LAST)) begin
            state_q <= IDLE;
            if (grant_lsu_q) begin
              lsu_rvalid_q <= 1'b1;
              lsu_err_q    <= !mem_resp_valid;
              lsu_rdata_q  <= mem_resp_valid ? mem_resp_rdata : '0;
            end else begin
              ifu_rvalid_q <= 1'b1;
              ifu_err_q    <= !mem_resp_valid;
              ifu_rdata_q  <= mem_resp_valid ? mem_resp_rdata : '0;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: begin
          state_q     <= IDLE;
          req_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req_valid = req_valid_q;
  assign mem_wen       = wen_q;
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;
  assign mem_wmask     = wmask_q;
  assign ifu_rvalid    = ifu_rvalid_q;
  assign ifu_err       = ifu_err_q;
  assign ifu_rdata     = ifu_rdata_q;
  assign lsu_rvalid    = lsu_rvalid_q;
  assign lsu_err       = lsu_err_q;
  assign lsu_rdata     = lsu_rdata_q;

endmodule
